// File: rtl/dpram_sync_init_if.sv
// Port bundle for dpram_sync_init: two independent request/response ports
// plus the shared status outputs.
interface dpram_sync_init_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 5
);
    logic              ena;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dia;
    logic [DATA_W-1:0] doa;
    logic              vala;
    logic              enb;
    logic              web;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] dib;
    logic [DATA_W-1:0] dob;
    logic              valb;
    logic              init_busy;
    logic              coll;

    modport master (
        output ena, wea, addra, dia, enb, web, addrb, dib,
        input  doa, vala, dob, valb, init_busy, coll
    );

    modport slave (
        input  ena, wea, addra, dia, enb, web, addrb, dib,
        output doa, vala, dob, valb, init_busy, coll
    );
endinterface

// File: rtl/dpram_sync_init.sv
// Single-clock true dual-port RAM with post-reset clear sweep, selectable
// read-during-write mode, optional output register and collision flag.
module dpram_sync_init #(
    parameter int              DATA_W    = 4,
    parameter int              ADDR_W    = 5,
    parameter int              DEPTH     = 32,
    parameter int              READ_MODE = 0,
    parameter int              OUT_REG   = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input logic              clk,
    input logic              rst,
    dpram_sync_init_if.slave bus
);

    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] sweep_addr;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              acc_a, acc_b;
    logic              in_a, in_b;
    logic              wr_a, wr_b;
    logic [DATA_W-1:0] rd_a, rd_b;

    logic [DATA_W-1:0] d1_a, d1_b;
    logic              v1_a, v1_b;
    logic              coll_q;

    // Requests are only honoured once the sweep is finished and reset is low.
    assign acc_a = (state == ST_RUN) && !rst && bus.ena;
    assign acc_b = (state == ST_RUN) && !rst && bus.enb;
    assign in_a  = ({1'b0, bus.addra} < DEPTH_C);
    assign in_b  = ({1'b0, bus.addrb} < DEPTH_C);
    assign wr_a  = acc_a && bus.wea && in_a;
    assign wr_b  = acc_b && bus.web && in_b;

    // Reading mem here sees the pre-edge contents, which gives read-first
    // behaviour and old data on the non-writing side of a collision.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // can leave it unassigned and infer a latch.
        rd_a = '0;
        rd_b = '0;
        if (in_a) begin
            rd_a = (READ_MODE != 0 && bus.wea) ? bus.dia : mem[bus.addra[IDX_W-1:0]];
        end
        if (in_b) begin
            rd_b = (READ_MODE != 0 && bus.web) ? bus.dib : mem[bus.addrb[IDX_W-1:0]];
        end
    end

    // Sweep FSM and first read stage.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state      <= ST_INIT;
            sweep_addr <= '0;
            d1_a       <= '0;
            d1_b       <= '0;
            v1_a       <= 1'b0;
            v1_b       <= 1'b0;
            coll_q     <= 1'b0;
        end else begin
            if (state == ST_INIT) begin
                sweep_addr <= sweep_addr + 1'b1;
                if (sweep_addr == LAST_ADDR) begin
                    state <= ST_RUN;
                end
            end
            v1_a <= acc_a;
            v1_b <= acc_b;
            if (acc_a) begin
                d1_a <= rd_a;
            end
            if (acc_b) begin
                d1_b <= rd_b;
            end
            coll_q <= acc_a && acc_b && in_a && (bus.addra == bus.addrb)
                      && (bus.wea || bus.web);
        end
    end

    // NOTE: the storage array has no reset branch; its contents are defined
    // by the clear sweep instead, which keeps it mappable to block RAM.
    always_ff @(posedge clk) begin
        if (!rst && state == ST_INIT) begin
            mem[sweep_addr[IDX_W-1:0]] <= INIT_VAL;
        end else begin
            if (wr_b) begin
                mem[bus.addrb[IDX_W-1:0]] <= bus.dib;
            end
            // Port A is written last so it wins a same-address double write.
            if (wr_a) begin
                mem[bus.addra[IDX_W-1:0]] <= bus.dia;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_W-1:0] d2_a, d2_b;
        logic              v2_a, v2_b;

        always_ff @(posedge clk) begin
            if (rst) begin
                d2_a <= '0;
                d2_b <= '0;
                v2_a <= 1'b0;
                v2_b <= 1'b0;
            end else begin
                v2_a <= v1_a;
                v2_b <= v1_b;
                if (v1_a) begin
                    d2_a <= d1_a;
                end
                if (v1_b) begin
                    d2_b <= d1_b;
                end
            end
        end

        assign bus.doa  = d2_a;
        assign bus.dob  = d2_b;
        assign bus.vala = v2_a;
        assign bus.valb = v2_b;
    end else begin : g_no_out_reg
        assign bus.doa  = d1_a;
        assign bus.dob  = d1_b;
        assign bus.vala = v1_a;
        assign bus.valb = v1_b;
    end

    assign bus.init_busy = (state == ST_INIT);
    assign bus.coll      = coll_q;

endmodule

// File: tb/tb_dpram_sync_init.sv
// Bench for dpram_sync_init: three parameter variants driven in lockstep and
// compared every cycle against an array-based reference model.
module tb_dpram_sync_init;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0, wea = 1'b0, enb = 1'b0, web = 1'b0;
    logic [4:0] addra = '0, addrb = '0;
    logic [3:0] dia = '0, dib = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dpram_sync_init_if #(.DATA_W(4), .ADDR_W(5)) if0 ();
    dpram_sync_init_if #(.DATA_W(4), .ADDR_W(5)) if1 ();
    dpram_sync_init_if #(.DATA_W(4), .ADDR_W(5)) if2 ();

    assign if0.ena = ena;  assign if0.wea = wea;  assign if0.addra = addra;  assign if0.dia = dia;
    assign if0.enb = enb;  assign if0.web = web;  assign if0.addrb = addrb;  assign if0.dib = dib;
    assign if1.ena = ena;  assign if1.wea = wea;  assign if1.addra = addra;  assign if1.dia = dia;
    assign if1.enb = enb;  assign if1.web = web;  assign if1.addrb = addrb;  assign if1.dib = dib;
    assign if2.ena = ena;  assign if2.wea = wea;  assign if2.addra = addra;  assign if2.dia = dia;
    assign if2.enb = enb;  assign if2.web = web;  assign if2.addrb = addrb;  assign if2.dib = dib;

    // Variant 0: read-first, latency 1. Variant 1: write-first, latency 2.
    // Variant 2: 20 words, read-first, latency 2.
    dpram_sync_init #(.DATA_W(4), .ADDR_W(5), .DEPTH(32), .READ_MODE(0), .OUT_REG(0),
                      .INIT_VAL(4'hA)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    dpram_sync_init #(.DATA_W(4), .ADDR_W(5), .DEPTH(32), .READ_MODE(1), .OUT_REG(1),
                      .INIT_VAL(4'hA)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    dpram_sync_init #(.DATA_W(4), .ADDR_W(5), .DEPTH(20), .READ_MODE(0), .OUT_REG(1),
                      .INIT_VAL(4'h5)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    logic [3:0] o_do   [3][2];
    logic       o_val  [3][2];
    logic       o_coll [3];
    logic       o_busy [3];

    assign o_do[0][0] = if0.doa;  assign o_do[0][1] = if0.dob;
    assign o_do[1][0] = if1.doa;  assign o_do[1][1] = if1.dob;
    assign o_do[2][0] = if2.doa;  assign o_do[2][1] = if2.dob;
    assign o_val[0][0] = if0.vala; assign o_val[0][1] = if0.valb;
    assign o_val[1][0] = if1.vala; assign o_val[1][1] = if1.valb;
    assign o_val[2][0] = if2.vala; assign o_val[2][1] = if2.valb;
    assign o_coll[0] = if0.coll;  assign o_coll[1] = if1.coll;  assign o_coll[2] = if2.coll;
    assign o_busy[0] = if0.init_busy; assign o_busy[1] = if1.init_busy; assign o_busy[2] = if2.init_busy;

    function automatic int dep(int k);   return (k == 2) ? 20 : 32; endfunction
    function automatic int rmode(int k); return (k == 1) ? 1 : 0;   endfunction
    function automatic int lat(int k);   return (k == 0) ? 1 : 2;   endfunction
    function automatic logic [3:0] ival(int k); return (k == 2) ? 4'h5 : 4'hA; endfunction

    // Reference model state: contents, remaining sweep cycles, and the
    // expected outputs fed through a delay line of length 1 or 2.
    logic [3:0] m_mem   [3][32];
    int         m_sweep [3];
    logic [3:0] m_do    [3][2];
    logic       m_val   [3][2];
    logic       m_coll  [3];
    logic [3:0] q_d     [3][2];
    logic       q_v     [3][2];

    task automatic model_edge();
        logic       en [2];
        logic       we [2];
        int         ad [2];
        logic [3:0] di [2];
        logic [3:0] r_d [2];
        logic       r_v [2];
        logic       c;
        en[0] = ena;  we[0] = wea;  ad[0] = int'(addra);  di[0] = dia;
        en[1] = enb;  we[1] = web;  ad[1] = int'(addrb);  di[1] = dib;
        for (int k = 0; k < 3; k++) begin
            r_v = '{1'b0, 1'b0};
            r_d = '{4'h0, 4'h0};
            c   = 1'b0;
            if (rst) begin
                m_sweep[k] = dep(k);
                for (int p = 0; p < 2; p++) begin
                    m_do[k][p] = '0; m_val[k][p] = 1'b0;
                    q_d[k][p]  = '0; q_v[k][p]   = 1'b0;
                end
                m_coll[k] = 1'b0;
                continue;
            end
            if (m_sweep[k] > 0) begin
                m_sweep[k]--;
                if (m_sweep[k] == 0) begin
                    for (int a = 0; a < 32; a++) m_mem[k][a] = ival(k);
                end
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (en[p]) begin
                        r_v[p] = 1'b1;
                        if (ad[p] >= dep(k))             r_d[p] = 4'h0;
                        else if (we[p] && rmode(k) == 1) r_d[p] = di[p];
                        else                             r_d[p] = m_mem[k][ad[p]];
                    end
                end
                c = en[0] && en[1] && ad[0] == ad[1] && ad[0] < dep(k) && (we[0] || we[1]);
                if (en[1] && we[1] && ad[1] < dep(k)) m_mem[k][ad[1]] = di[1];
                if (en[0] && we[0] && ad[0] < dep(k)) m_mem[k][ad[0]] = di[0];
            end
            m_coll[k] = c;
            for (int p = 0; p < 2; p++) begin
                if (lat(k) == 1) begin
                    m_val[k][p] = r_v[p];
                    if (r_v[p]) m_do[k][p] = r_d[p];
                end else begin
                    m_val[k][p] = q_v[k][p];
                    if (q_v[k][p]) m_do[k][p] = q_d[k][p];
                    q_v[k][p] = r_v[p];
                    if (r_v[p]) q_d[k][p] = r_d[p];
                end
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d.doa", k),  32'(o_do[k][0]),  32'(m_do[k][0]));
            chk($sformatf("u%0d.dob", k),  32'(o_do[k][1]),  32'(m_do[k][1]));
            chk($sformatf("u%0d.vala", k), 32'(o_val[k][0]), 32'(m_val[k][0]));
            chk($sformatf("u%0d.valb", k), 32'(o_val[k][1]), 32'(m_val[k][1]));
            chk($sformatf("u%0d.coll", k), 32'(o_coll[k]),   32'(m_coll[k]));
            chk($sformatf("u%0d.busy", k), 32'(o_busy[k]),   32'(m_sweep[k] > 0));
        end
    endtask

    task automatic set_a(logic en, logic we, int ad, logic [3:0] d);
        ena = en; wea = we; addra = 5'(ad); dia = d;
    endtask

    task automatic set_b(logic en, logic we, int ad, logic [3:0] d);
        enb = en; web = we; addrb = 5'(ad); dib = d;
    endtask

    task automatic idle();
        set_a(1'b0, 1'b0, 0, 4'h0);
        set_b(1'b0, 1'b0, 0, 4'h0);
    endtask

    initial begin
        int busy_cycles;
        for (int k = 0; k < 3; k++) begin
            m_sweep[k] = 0;
            m_coll[k]  = 1'b0;
            for (int a = 0; a < 32; a++) m_mem[k][a] = 'x;
            for (int p = 0; p < 2; p++) begin
                m_do[k][p] = '0; m_val[k][p] = 1'b0; q_d[k][p] = '0; q_v[k][p] = 1'b0;
            end
        end
        @(negedge clk);

        // Reset held three cycles, then a sweep interrupted at cycle 10 while
        // port A tries to write.
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        set_a(1'b1, 1'b1, 3, 4'hF);
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        busy_cycles = 0;
        repeat (40) begin
            if (o_busy[0]) busy_cycles++;
            step();
        end
        chk("busy_len_u0", 32'(busy_cycles), 32'd32);
        idle();

        // Every word reads back the sweep value.
        for (int a = 0; a < 32; a++) begin
            set_a(1'b1, 1'b0, a, 4'h0);
            step();
        end
        idle();
        repeat (2) step();

        // Write on A, read on B the next cycle.
        set_a(1'b1, 1'b1, 3, 4'h5);
        step();
        idle();
        set_b(1'b1, 1'b0, 3, 4'h0);
        step();
        idle();
        repeat (2) step();
        chk("rw_dob_u0", 32'(o_do[0][1]), 32'h5);
        chk("rw_dob_u1", 32'(o_do[1][1]), 32'h5);

        // Same-port read-during-write.
        set_a(1'b1, 1'b1, 7, 4'h1);
        step();
        set_a(1'b1, 1'b1, 7, 4'h9);
        step();
        chk("rdw_doa_u0", 32'(o_do[0][0]), 32'h1);
        idle();
        step();
        chk("rdw_doa_u1", 32'(o_do[1][0]), 32'h9);
        step();

        // Double write collision, read-back, then write/read collision.
        set_a(1'b1, 1'b1, 12, 4'h3);
        set_b(1'b1, 1'b1, 12, 4'hC);
        step();
        chk("coll_ww_u0", 32'(o_coll[0]), 32'h1);
        idle();
        step();
        chk("coll_clear_u0", 32'(o_coll[0]), 32'h0);
        set_a(1'b1, 1'b0, 12, 4'h0);
        step();
        chk("coll_keep_a_u0", 32'(o_do[0][0]), 32'h3);
        set_a(1'b1, 1'b1, 12, 4'h6);
        set_b(1'b1, 1'b0, 12, 4'h0);
        step();
        chk("coll_wr_old_u0", 32'(o_do[0][1]), 32'h3);
        idle();
        repeat (2) step();
        chk("coll_wr_old_u1", 32'(o_do[1][1]), 32'h3);

        // Out-of-range write and read on the 20-word variant.
        set_a(1'b1, 1'b1, 25, 4'h7);
        step();
        set_a(1'b1, 1'b0, 25, 4'h0);
        step();
        idle();
        step();
        chk("oor_doa_u2", 32'(o_do[2][0]), 32'h0);
        chk("oor_vala_u2", 32'(o_val[2][0]), 32'h1);
        step();

        // Back-to-back reads on both ports.
        for (int a = 0; a < 20; a++) begin
            set_a(1'b1, 1'b0, a, 4'h0);
            set_b(1'b1, 1'b0, 19 - a, 4'h0);
            step();
        end
        idle();
        repeat (2) step();

        // Random traffic, biased towards a small address window so that
        // collisions and same-address reads occur often.
        for (int i = 0; i < 500; i++) begin
            set_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(10, 13)),
                  4'($urandom));
            set_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(10, 13)),
                  4'($urandom));
            step();
        end
        idle();
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
